// File: rtl/axi4_burst_mem_slave.sv
// AXI4 full slave fronting a word-addressed memory window with FIXED/INCR/WRAP bursts.
// Read and write engines run independently at one beat per cycle; reads are read-first on collision.
module axi4_burst_mem_slave #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ID_W   = 1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ID_W-1:0]       S_AXI_AWID,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_W-1:0]       S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ID_W-1:0]       S_AXI_ARID,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_W-1:0]       S_AXI_RID,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Address of the following beat; FIXED (and reserved) bursts stay put.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       burst,
                                                  input logic [7:0]       len);
        logic [IDX_W-1:0] mask;
        logic [IDX_W-1:0] inc;
        mask = IDX_W'(len);
        inc  = idx + IDX_W'(1);
        case (burst)
            BURST_INCR: next_idx = inc;
            BURST_WRAP: next_idx = (idx & ~mask) | (inc & mask);
            default:    next_idx = idx;
        endcase
    endfunction

    // Reserved burst type or a WRAP length the window cannot honour.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_illegal = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state;
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [1:0]        b_resp;
    logic [ID_W-1:0]   b_id;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_len;
    logic [1:0]        w_burst;
    logic [7:0]        w_cnt;
    logic              w_err;
    logic              w_last_err;
    logic              mem_we;

    r_state_t          r_state;
    logic              ar_ready;
    logic              r_valid;
    logic              r_last;
    logic [1:0]        r_resp;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  ar_idx;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              ar_err;

    // Address bits above the window alias; bits below the word are ignored.
    logic unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign ar_idx = S_AXI_ARADDR[LSB +: IDX_W];
    assign ar_err = burst_illegal(S_AXI_ARBURST, S_AXI_ARLEN);
    assign mem_we = (w_state == W_DATA) && w_ready && S_AXI_WVALID && !w_err;

    // Write engine: address latch, beat counting, response generation.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state    <= W_IDLE;
            aw_ready   <= 1'b0;
            w_ready    <= 1'b0;
            b_valid    <= 1'b0;
            b_resp     <= RESP_OKAY;
            b_id       <= '0;
            w_idx      <= '0;
            w_len      <= '0;
            w_burst    <= '0;
            w_cnt      <= '0;
            w_err      <= 1'b0;
            w_last_err <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_ready <= 1'b1;
                    if (aw_ready && S_AXI_AWVALID) begin
                        aw_ready   <= 1'b0;
                        w_ready    <= 1'b1;
                        b_id       <= S_AXI_AWID;
                        w_idx      <= S_AXI_AWADDR[LSB +: IDX_W];
                        w_len      <= S_AXI_AWLEN;
                        w_burst    <= S_AXI_AWBURST;
                        w_cnt      <= '0;
                        w_err      <= burst_illegal(S_AXI_AWBURST, S_AXI_AWLEN);
                        w_last_err <= 1'b0;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_ready && S_AXI_WVALID) begin
                        w_idx <= next_idx(w_idx, w_burst, w_len);
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= (w_err || w_last_err || !S_AXI_WLAST) ? RESP_SLVERR
                                                                             : RESP_OKAY;
                            w_state <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            w_last_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is never reset; byte lanes are written under strobe.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Read engine: r_idx always points at the beat to present after the current one.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_id     <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_ready <= 1'b1;
                    if (ar_ready && S_AXI_ARVALID) begin
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_id     <= S_AXI_ARID;
                        r_len    <= S_AXI_ARLEN;
                        r_burst  <= S_AXI_ARBURST;
                        r_cnt    <= '0;
                        r_err    <= ar_err;
                        r_resp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_data   <= ar_err ? '0 : mem[ar_idx];
                        r_last   <= (S_AXI_ARLEN == 8'd0);
                        r_idx    <= next_idx(ar_idx, S_AXI_ARBURST, S_AXI_ARLEN);
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_data <= r_err ? '0 : mem[r_idx];
                            r_idx  <= next_idx(r_idx, r_burst, r_len);
                            r_cnt  <= r_cnt + 8'd1;
                            r_last <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_BID     = b_id;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RLAST   = r_last;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = r_data;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Bench for axi4_burst_mem_slave: randomized bursts checked against a flat word-array memory model.
`timescale 1ns/1ps
module tb_axi4_burst_mem_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int ID_W   = 2;
    localparam int TMO    = 200;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic              tb_rst_n;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    axi4_burst_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W)
    ) dut (
        .S_AXI_ACLK(tb_ACLK),     .S_AXI_ARESETN(tb_rst_n),
        .S_AXI_AWID(awid),        .S_AXI_AWADDR(awaddr),   .S_AXI_AWLEN(awlen),
        .S_AXI_AWBURST(awburst),  .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),      .S_AXI_WSTRB(wstrb),     .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid),    .S_AXI_WREADY(wready),
        .S_AXI_BID(bid),          .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid),        .S_AXI_ARADDR(araddr),   .S_AXI_ARLEN(arlen),
        .S_AXI_ARBURST(arburst),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid),          .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast),      .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0]     model_mem [DEPTH];
    logic [31:0]     wbuf      [256];
    logic [3:0]      sbuf      [256];
    logic [31:0]     rbuf      [256];
    logic [1:0]      rrbuf     [256];
    logic            rlbuf     [256];
    logic [ID_W-1:0] ridbuf    [256];

    // Word touched by beat k, from the burst address rules stated as plain arithmetic.
    function automatic int beat_idx(input logic [31:0] addr, input int len,
                                    input logic [1:0] burst, input int k);
        int start;
        int n;
        int base;
        start = int'(addr[7:2]);
        n     = len + 1;
        base  = start - (start % n);
        case (burst)
            FIXED:   return start;
            INCR:    return (start + k) % DEPTH;
            default: return base + ((start % n) + k) % n;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input int nbeats);
        int idx;
        for (int k = 0; k < nbeats; k++) begin
            idx = beat_idx(addr, len, burst, k);
            for (int b = 0; b < 4; b++)
                if (sbuf[k][b]) model_mem[idx][b*8 +: 8] = wbuf[k][b*8 +: 8];
        end
    endtask

    // Drives one write burst; abort_beat >= 0 pulls reset while that beat is offered.
    task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input bit early_last, input int abort_beat,
                             output logic [ID_W-1:0] bid_o, output logic [1:0] bresp_o);
        int t;
        bid_o = '0;
        bresp_o = 2'b00;
        @(negedge tb_ACLK);
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin @(negedge tb_ACLK); t++; end
        if (t >= TMO) begin
            n_checks++; n_fails++;
            $display("FAIL aw_timeout: awready low for %0d cycles, required 1", t);
        end
        @(negedge tb_ACLK);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata = wbuf[k]; wstrb = sbuf[k]; wvalid = 1'b1;
            wlast = early_last ? (k == 0) : (k == len);
            t = 0;
            while (!wready && t < TMO) begin @(negedge tb_ACLK); t++; end
            if (t >= TMO) begin
                n_checks++; n_fails++;
                $display("FAIL w_timeout: beat %0d wready low for %0d cycles, required 1", k, t);
            end
            if (k == abort_beat) begin
                tb_rst_n = 1'b0;
                #1;
                return;
            end
            @(negedge tb_ACLK);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < TMO) begin @(negedge tb_ACLK); t++; end
        if (t >= TMO) begin
            n_checks++; n_fails++;
            $display("FAIL b_timeout: bvalid low for %0d cycles, required 1", t);
        end
        bid_o = bid; bresp_o = bresp;
        @(negedge tb_ACLK);
        bready = 1'b0;
    endtask

    // Collects one read burst into rbuf; mode 0 always ready, 1 pattern 1,0,0,1, else random.
    task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int mode);
        int t;
        int beats;
        bit stalled;
        logic [31:0] h_data;
        logic [1:0] h_resp;
        logic h_last;
        logic [ID_W-1:0] h_id;
        @(negedge tb_ACLK);
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(negedge tb_ACLK); t++; end
        if (t >= TMO) begin
            n_checks++; n_fails++;
            $display("FAIL ar_timeout: arready low for %0d cycles, required 1", t);
        end
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        beats = 0; t = 0; stalled = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0;
        while (beats <= len && t < 4 * TMO) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = ((t % 4) == 0) || ((t % 4) == 3);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (stalled && rvalid) begin
                n_checks++;
                if ({rdata, rresp, rlast, rid} !== {h_data, h_resp, h_last, h_id}) begin
                    n_fails++;
                    $display("FAIL r_stall_stable: beat %0d got %h/%b/%b/%h required %h/%b/%b/%h",
                             beats, rdata, rresp, rlast, rid, h_data, h_resp, h_last, h_id);
                end
            end
            if (rvalid && rready) begin
                rbuf[beats] = rdata; rrbuf[beats] = rresp;
                rlbuf[beats] = rlast; ridbuf[beats] = rid;
                beats++;
                stalled = 1'b0;
            end else if (rvalid) begin
                stalled = 1'b1;
                h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
            end else begin
                stalled = 1'b0;
            end
            @(negedge tb_ACLK);
            t++;
        end
        rready = 1'b0;
        if (beats <= len) begin
            n_checks++; n_fails++;
            $display("FAIL r_timeout: got %0d beats, required %0d", beats, len + 1);
        end
    endtask

    // Per-beat check of a collected read against the model (or zero for error bursts).
    task automatic check_read(input string name, input logic [ID_W-1:0] id, input logic [31:0] addr,
                              input int len, input logic [1:0] burst, input bit err);
        logic [31:0] exp_d;
        for (int k = 0; k <= len; k++) begin
            exp_d = err ? 32'h0 : model_mem[beat_idx(addr, len, burst, k)];
            n_checks++;
            if (rbuf[k] !== exp_d) begin
                n_fails++;
                $display("FAIL %s data beat %0d: got %h required %h", name, k, rbuf[k], exp_d);
            end
            n_checks++;
            if ({ridbuf[k], rrbuf[k], rlbuf[k]} !== {id, (err ? 2'b10 : 2'b00), 1'(k == len)}) begin
                n_fails++;
                $display("FAIL %s ctl beat %0d: got id %h resp %b last %b required id %h resp %b last %b",
                         name, k, ridbuf[k], rrbuf[k], rlbuf[k], id, (err ? 2'b10 : 2'b00), (k == len));
            end
        end
    endtask

    task automatic test_reset();
        tb_rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            n_fails++;
            $display("FAIL reset_handshake: got %b required 000000",
                     {awready, wready, bvalid, arready, rvalid, rlast});
        end
        n_checks++;
        if ({bresp, rresp, rdata, bid, rid} !== '0) begin
            n_fails++;
            $display("FAIL reset_payload: got bresp %b rresp %b rdata %h bid %h rid %h required zeros",
                     bresp, rresp, rdata, bid, rid);
        end
        tb_rst_n = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        n_checks++;
        if ({awready, arready} !== 2'b11) begin
            n_fails++;
            $display("FAIL reset_idle_ready: got %b required 11", {awready, arready});
        end
    endtask

    task automatic test_incr_wrap();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        for (int k = 0; k < 16; k++) begin wbuf[k] = 32'h1111_1111 * k; sbuf[k] = 4'hF; end
        axi_write(2'd1, 32'h0, 15, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h0, 15, INCR, 16);
        n_checks++;
        if ({b_id, b_resp} !== {2'd1, 2'b00}) begin
            n_fails++;
            $display("FAIL incr16_b: got bid %h bresp %b required bid 1 bresp 00", b_id, b_resp);
        end
        axi_read(2'd2, 32'h0, 15, WRAP, 0);
        check_read("wrap16", 2'd2, 32'h0, 15, WRAP, 1'b0);
        n_checks++;
        if (rbuf[15] !== 32'hFFFF_FFFF) begin
            n_fails++;
            $display("FAIL wrap16_last_word: got %h required ffffffff", rbuf[15]);
        end
    endtask

    task automatic test_strobe();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        wbuf[0] = 32'h1111_1111; sbuf[0] = 4'hF;
        axi_write(2'd0, 32'h10, 0, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h10, 0, INCR, 1);
        wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0011;
        axi_write(2'd3, 32'h10, 0, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h10, 0, INCR, 1);
        n_checks++;
        if ({b_id, b_resp} !== {2'd3, 2'b00}) begin
            n_fails++;
            $display("FAIL strobe_b: got bid %h bresp %b required bid 3 bresp 00", b_id, b_resp);
        end
        axi_read(2'd1, 32'h10, 0, INCR, 0);
        check_read("strobe", 2'd1, 32'h10, 0, INCR, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'h1111_CCDD) begin
            n_fails++;
            $display("FAIL strobe_merge: got %h required 1111ccdd", rbuf[0]);
        end
    endtask

    task automatic test_wrap_boundary();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        logic [31:0] exp4 [4];
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hA0 + 32'(k); sbuf[k] = 4'hF; end
        axi_write(2'd0, 32'h0, 3, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h0, 3, INCR, 4);
        wbuf[0] = $urandom(); sbuf[0] = 4'hF;
        axi_write(2'd0, 32'((DEPTH - 1) * 4), 0, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'((DEPTH - 1) * 4), 0, INCR, 1);
        axi_read(2'd0, 32'h08, 3, WRAP, 0);
        check_read("wrap4", 2'd0, 32'h08, 3, WRAP, 1'b0);
        exp4 = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rbuf[k] !== exp4[k]) begin
                n_fails++;
                $display("FAIL wrap4_order beat %0d: got %h required %h", k, rbuf[k], exp4[k]);
            end
        end
        axi_read(2'd1, 32'((DEPTH - 1) * 4), 1, INCR, 2);
        check_read("incr_rollover", 2'd1, 32'((DEPTH - 1) * 4), 1, INCR, 1'b0);
    endtask

    task automatic test_fixed_stall();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'(k + 1); sbuf[k] = 4'hF; end
        axi_write(2'd2, 32'h04, 3, FIXED, 1'b0, -1, b_id, b_resp);
        model_write(32'h04, 3, FIXED, 4);
        axi_read(2'd3, 32'h04, 3, INCR, 1);
        check_read("stall_incr", 2'd3, 32'h04, 3, INCR, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'd4) begin
            n_fails++;
            $display("FAIL fixed_final_word: got %h required 00000004", rbuf[0]);
        end
        axi_read(2'd0, 32'h04, 3, FIXED, 2);
        check_read("fixed_read", 2'd0, 32'h04, 3, FIXED, 1'b0);
    endtask

    task automatic test_slverr();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        for (int k = 0; k < 2; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd0, 32'h20, 1, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h20, 1, INCR, 2);
        for (int k = 0; k < 3; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd2, 32'h20, 1, RSVD, 1'b0, -1, b_id, b_resp);
        n_checks++;
        if ({b_id, b_resp} !== {2'd2, 2'b10}) begin
            n_fails++;
            $display("FAIL rsvd_write_b: got bid %h bresp %b required bid 2 bresp 10", b_id, b_resp);
        end
        axi_write(2'd1, 32'h20, 2, WRAP, 1'b0, -1, b_id, b_resp);
        n_checks++;
        if (b_resp !== 2'b10) begin
            n_fails++;
            $display("FAIL wrap_len_write_b: got bresp %b required 10", b_resp);
        end
        axi_read(2'd1, 32'h20, 1, INCR, 0);
        check_read("err_mem_unchanged", 2'd1, 32'h20, 1, INCR, 1'b0);
        axi_read(2'd3, 32'h20, 2, RSVD, 2);
        check_read("rsvd_read", 2'd3, 32'h20, 2, RSVD, 1'b1);
        axi_read(2'd2, 32'h20, 2, WRAP, 0);
        check_read("wrap_len_read", 2'd2, 32'h20, 2, WRAP, 1'b1);
        for (int k = 0; k < 2; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd1, 32'h20, 1, INCR, 1'b1, -1, b_id, b_resp);
        model_write(32'h20, 1, INCR, 2);
        n_checks++;
        if (b_resp !== 2'b10) begin
            n_fails++;
            $display("FAIL wlast_mismatch_b: got bresp %b required 10", b_resp);
        end
        axi_read(2'd0, 32'h20, 1, INCR, 0);
        check_read("wlast_mismatch_data", 2'd0, 32'h20, 1, INCR, 1'b0);
    endtask

    task automatic test_random();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        logic [ID_W-1:0] id;
        logic [31:0] addr;
        logic [1:0] burst;
        int len;
        int wrap_lens [4];
        wrap_lens = '{1, 3, 7, 15};
        for (int k = 0; k < DEPTH; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd0, 32'h0, DEPTH - 1, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'h0, DEPTH - 1, INCR, DEPTH);
        for (int it = 0; it < 6; it++) begin
            burst = 2'($urandom_range(0, 2));
            len = (burst == WRAP) ? wrap_lens[$urandom_range(0, 3)] : int'($urandom_range(0, 20));
            addr = $urandom() & 32'hFFFF_FFFC;
            id = 2'($urandom_range(0, 3));
            for (int k = 0; k <= len; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'($urandom()); end
            axi_write(id, addr, len, burst, 1'b0, -1, b_id, b_resp);
            model_write(addr, len, burst, len + 1);
            n_checks++;
            if ({b_id, b_resp} !== {id, 2'b00}) begin
                n_fails++;
                $display("FAIL rand_b it %0d: got bid %h bresp %b required bid %h bresp 00",
                         it, b_id, b_resp, id);
            end
            burst = 2'($urandom_range(0, 2));
            len = (burst == WRAP) ? wrap_lens[$urandom_range(0, 3)] : int'($urandom_range(0, 20));
            addr = $urandom() & 32'hFFFF_FFFC;
            id = 2'($urandom_range(0, 3));
            axi_read(id, addr, len, burst, 2);
            check_read("rand_read", id, addr, len, burst, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        for (int k = 0; k < 8; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        fork
            axi_write(2'd1, 32'(40 * 4), 7, INCR, 1'b0, -1, b_id, b_resp);
            axi_read(2'd2, 32'h0, 7, INCR, 0);
        join
        check_read("concurrent_read", 2'd2, 32'h0, 7, INCR, 1'b0);
        model_write(32'(40 * 4), 7, INCR, 8);
        n_checks++;
        if (b_resp !== 2'b00) begin
            n_fails++;
            $display("FAIL concurrent_b: got bresp %b required 00", b_resp);
        end
        axi_read(2'd3, 32'(40 * 4), 7, INCR, 0);
        check_read("concurrent_wb", 2'd3, 32'(40 * 4), 7, INCR, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        logic [ID_W-1:0] b_id;
        logic [1:0] b_resp;
        for (int k = 0; k < 8; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd1, 32'h80, 7, INCR, 1'b0, 3, b_id, b_resp);
        n_checks++;
        if ({wready, bvalid} !== 2'b00) begin
            n_fails++;
            $display("FAIL abort_outputs: got wready %b bvalid %b required 0 0", wready, bvalid);
        end
        model_write(32'h80, 7, INCR, 3);
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge tb_ACLK);
        tb_rst_n = 1'b1;
        @(negedge tb_ACLK);
        for (int k = 0; k < 2; k++) begin wbuf[k] = $urandom(); sbuf[k] = 4'hF; end
        axi_write(2'd2, 32'hC0, 1, INCR, 1'b0, -1, b_id, b_resp);
        model_write(32'hC0, 1, INCR, 2);
        n_checks++;
        if ({b_id, b_resp} !== {2'd2, 2'b00}) begin
            n_fails++;
            $display("FAIL post_abort_b: got bid %h bresp %b required bid 2 bresp 00", b_id, b_resp);
        end
        axi_read(2'd0, 32'h80, 3, INCR, 0);
        check_read("abort_kept", 2'd0, 32'h80, 3, INCR, 1'b0);
    endtask

    initial begin
        test_reset();
        test_incr_wrap();
        test_strobe();
        test_wrap_boundary();
        test_fixed_stall();
        test_slverr();
        test_random();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
